// File: rtl/fetch_execute_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_execute_sequencer
// Purpose  : Bus initiator for the accumulator CPU. Owns PC, MAR, MBR, IR and
//            ACC and steps fetch -> decode -> operand access -> execute
//            against main memory over a registered req/ack handshake.
// Ports    : clock, reset      rising-edge clock, synchronous active-high reset
//            run               level enable, sampled in IDLE and FETCH
//            mem_req/mem_we    request valid / write select (registered)
//            mem_addr          request address (MAR, registered)
//            mem_wdata         write data (ACC, registered)
//            mem_ack/mem_rdata responder completion / read data
//            acc_out, pc_out   architectural accumulator and program counter
//            halted            HALT state reached
//            fault             0 none, 1 illegal opcode, 2 ack timeout
// Revision : 1.0 - initial release
// ============================================================================
module fetch_execute_sequencer #(
  parameter int ADDR_W      = 12,  // must not exceed 12 (opcode lives in [15:12])
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 15   // must be >= 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [1:0]        fault
);

  // Counter only needs to reach ACK_TIMEOUT-1; the wait that would make it
  // reach ACK_TIMEOUT is the one that raises the timeout instead.
  localparam int                CNT_W      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_MEM_REQ    = 4'd4,
    S_MEM_WAIT   = 4'd5,
    S_EXECUTE    = 4'd6,
    S_HALT       = 4'd7,
    S_FAULT      = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic [15:0]       mbr_q,   mbr_d;
  logic [15:0]       ir_q,    ir_d;
  logic [15:0]       acc_q,   acc_d;
  logic              req_q,   req_d;
  logic              we_q,    we_d;
  logic [CNT_W-1:0]  wait_q,  wait_d;
  logic [1:0]        fault_q, fault_d;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr;
  logic              w_timeout;

  assign w_opcode  = ir_q[15:12];
  assign w_addr    = ir_q[ADDR_W-1:0];
  assign w_timeout = (wait_q == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_C;
      mar_q   <= '0;
      mbr_q   <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    req_d   = req_q;
    we_d    = we_q;
    wait_d  = wait_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      // run is checked here so an instruction is never abandoned once its
      // fetch has been issued.
      S_FETCH: begin
        if (run) begin
          mar_d   = pc_q;
          req_d   = 1'b1;
          we_d    = 1'b0;
          wait_d  = '0;
          state_d = S_FETCH_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH_WAIT: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          req_d   = 1'b0;
          state_d = S_DECODE;
        end else if (w_timeout) begin
          req_d   = 1'b0;
          fault_d = FAULT_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        case (w_opcode)
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_d    = w_addr;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (acc_q == 16'h0000) pc_d = w_addr;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEM_REQ;
          default: begin
            fault_d = FAULT_ILLEGAL;
            state_d = S_FAULT;
          end
        endcase
      end

      S_MEM_REQ: begin
        mar_d   = w_addr;
        req_d   = 1'b1;
        we_d    = (w_opcode == OP_STORE);
        wait_d  = '0;
        state_d = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        if (mem_ack) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (we_q) begin
            state_d = S_FETCH;
          end else begin
            mbr_d   = mem_rdata;
            state_d = S_EXECUTE;
          end
        end else if (w_timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          fault_d = FAULT_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          wait_d  = wait_q + CNT_W'(1);
        end
      end

      S_EXECUTE: begin
        case (w_opcode)
          OP_LOAD: acc_d = mbr_q;
          OP_ADD:  acc_d = acc_q + mbr_q;
          OP_SUB:  acc_d = acc_q - mbr_q;
          OP_AND:  acc_d = acc_q & mbr_q;
          OP_OR:   acc_d = acc_q | mbr_q;
          default: acc_d = acc_q;
        endcase
        state_d = S_FETCH;
      end

      // Terminal states: only reset leaves them.
      S_HALT, S_FAULT: state_d = state_q;

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = acc_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_execute_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_execute_sequencer
// Purpose  : Self-checking bench for fetch_execute_sequencer with a behavioural
//            memory responder (configurable wait states / never-ack).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_execute_sequencer;

  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              run   = 1'b0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack   = 1'b0;
  logic [15:0]       mem_rdata = 16'h0000;
  logic [15:0]       acc_out;
  logic [ADDR_W-1:0] pc_out;
  logic              halted;
  logic [1:0]        fault;

  fetch_execute_sequencer #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (0),
    .ACK_TIMEOUT (15)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [15:0]       mem [0:4095];
  int                waits     = 0;
  bit                never_ack = 1'b0;
  bit                hs_chk    = 1'b0;
  logic [ADDR_W-1:0] req_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder and handshake monitor, both working on the falling edge.
  initial begin : responder
    int                cnt;
    bit                prev_req;
    bit                prev_ack;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [15:0]       s_wd;
    cnt = 0; prev_req = 1'b0; prev_ack = 1'b0;
    s_addr = '0; s_we = 1'b0; s_wd = '0;
    forever begin
      @(negedge clock);
      if (hs_chk) begin
        if (prev_ack) begin
          chk("req_drop_after_ack", {31'd0, mem_req}, 32'd0);
        end else if (prev_req && mem_req) begin
          chk("addr_stable", {20'd0, mem_addr}, {20'd0, s_addr});
          chk("we_stable", {31'd0, mem_we}, {31'd0, s_we});
          if (s_we) chk("wdata_stable", {16'd0, mem_wdata}, {16'd0, s_wd});
        end
      end
      if (mem_req && !prev_req) req_log.push_back(mem_addr);
      s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata; prev_req = mem_req;
      if (reset || !mem_req || never_ack) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (cnt >= waits) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
      prev_ack = mem_ack;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  // Leaves the bench at a falling edge with reset released and run low.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    req_log.delete();
  endtask

  // Raises run and counts rising edges until halted or fault.
  task automatic run_prog(input int max, output int cyc);
    run = 1'b1;
    cyc = 0;
    while (!halted && fault == 2'd0 && cyc < max) begin
      @(posedge clock);
      cyc++;
      #1;
    end
    if (cyc >= max) chk("run_budget", cyc, 32'd0);
  endtask

  function automatic logic [ADDR_W-1:0] next_after(input logic [ADDR_W-1:0] a);
    for (int i = 0; i + 1 < req_log.size(); i++)
      if (req_log[i] == a) return req_log[i+1];
    return '1;
  endfunction

  typedef struct {
    logic [15:0]       acc0;
    logic [15:0]       instr;
    logic [15:0]       opnd;
    logic [15:0]       exp_acc;
    logic [ADDR_W-1:0] exp_pc;
    logic [15:0]       exp_m20;
    int                exp_cyc;
  } vec_t;

  vec_t vecs [12];

  initial begin : main
    int cyc;
    bit ok;
    bit seen;

    // acc0 is loaded by LOAD 0x0F0 at mem[0]; the instruction under test is
    // mem[1] with its operand at 0x020; mem[2] and mem[0x030] hold HALT.
    // Cycles = 1 (IDLE) + 6 (LOAD) + instr + 3 (HALT).
    vecs[0]  = '{16'h1234, 16'h1020, 16'hBEEF, 16'hBEEF, 12'h003, 16'hBEEF, 16};
    vecs[1]  = '{16'h0005, 16'h3020, 16'h0007, 16'h000C, 12'h003, 16'h0007, 16};
    vecs[2]  = '{16'h8000, 16'h3020, 16'h8001, 16'h0001, 12'h003, 16'h8001, 16};
    vecs[3]  = '{16'h0003, 16'h4020, 16'h0005, 16'hFFFE, 12'h003, 16'h0005, 16};
    vecs[4]  = '{16'hF0F0, 16'h5020, 16'h3C3C, 16'h3030, 12'h003, 16'h3C3C, 16};
    vecs[5]  = '{16'hF0F0, 16'h6020, 16'h0F01, 16'hFFF1, 12'h003, 16'h0F01, 16};
    vecs[6]  = '{16'hA5A5, 16'h2020, 16'h0000, 16'hA5A5, 12'h003, 16'hA5A5, 15};
    vecs[7]  = '{16'h0001, 16'h7030, 16'h1111, 16'h0001, 12'h031, 16'h1111, 13};
    vecs[8]  = '{16'h0000, 16'h8030, 16'h2222, 16'h0000, 12'h031, 16'h2222, 13};
    vecs[9]  = '{16'h0007, 16'h8030, 16'h3333, 16'h0007, 12'h003, 16'h3333, 13};
    vecs[10] = '{16'h4444, 16'h0000, 16'h5555, 16'h4444, 12'h002, 16'h5555, 10};
    vecs[11] = '{16'h0042, 16'h7FFF, 16'h0000, 16'h0042, 12'h000, 16'h0000, 13};

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req",    {31'd0, mem_req}, 32'd0);
    chk("rst_we",     {31'd0, mem_we},  32'd0);
    chk("rst_acc",    {16'd0, acc_out}, 32'd0);
    chk("rst_pc",     {20'd0, pc_out},  32'd0);
    chk("rst_halted", {31'd0, halted},  32'd0);
    chk("rst_fault",  {30'd0, fault},   32'd0);

    // Table-driven single-instruction vectors, zero-wait memory.
    waits = 0;
    for (int v = 0; v < 12; v++) begin
      clear_mem();
      mem[0]      = 16'h10F0;
      mem[1]      = vecs[v].instr;
      mem[2]      = 16'h0000;
      mem[12'h0F0] = vecs[v].acc0;
      mem[12'h020] = vecs[v].opnd;
      do_reset();
      run_prog(100, cyc);
      chk($sformatf("v%0d_acc", v),    {16'd0, acc_out}, {16'd0, vecs[v].exp_acc});
      chk($sformatf("v%0d_pc", v),     {20'd0, pc_out},  {20'd0, vecs[v].exp_pc});
      chk($sformatf("v%0d_m20", v),    {16'd0, mem[12'h020]}, {16'd0, vecs[v].exp_m20});
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_halted", v), {31'd0, halted}, 32'd1);
    end

    // Reference program, zero-wait then 3 wait states with handshake checks.
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h0000;
      mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h0002;
      waits = (pass == 0) ? 0 : 3;
      do_reset();
      hs_chk = (pass == 1);
      run_prog(200, cyc);
      @(negedge clock);
      hs_chk = 1'b0;
      chk($sformatf("prog%0d_m12", pass),    {16'd0, mem[12'h012]}, 32'h0001);
      chk($sformatf("prog%0d_halted", pass), {31'd0, halted}, 32'd1);
      chk($sformatf("prog%0d_pc", pass),     {20'd0, pc_out}, 32'h004);
      chk($sformatf("prog%0d_cycles", pass), cyc, (pass == 0) ? 32'd21 : 32'd42);
    end

    // Reset while the second LOAD waits for its operand.
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h1011;
    mem[12'h010] = 16'hFFFF; mem[12'h011] = 16'h1234;
    waits = 5;
    do_reset();
    run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (mem_req && mem_addr == 12'h011) seen = 1'b1;
    end
    chk("midrst_reached", {31'd0, seen}, 32'd1);
    chk("midrst_pre_acc", {16'd0, acc_out}, 32'hFFFF);
    chk("midrst_pre_pc",  {20'd0, pc_out},  32'h002);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_req",   {31'd0, mem_req}, 32'd0);
    chk("midrst_pc",    {20'd0, pc_out},  32'd0);
    chk("midrst_acc",   {16'd0, acc_out}, 32'd0);
    chk("midrst_fault", {30'd0, fault},   32'd0);
    reset = 1'b0;
    run   = 1'b0;
    waits = 0;

    // JZ at mem[5], taken and not taken.
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      mem[0] = 16'h10F0; mem[1] = 16'h7005; mem[5] = 16'h8020;
      mem[6] = 16'h0000; mem[12'h020] = 16'h0000;
      mem[12'h0F0] = (pass == 0) ? 16'h0000 : 16'h0007;
      do_reset();
      run_prog(100, cyc);
      chk($sformatf("jz%0d_next_fetch", pass), {20'd0, next_after(12'h005)},
          (pass == 0) ? 32'h020 : 32'h006);
    end

    // Illegal opcode: sticky fault, no further requests, run ignored.
    clear_mem();
    mem[0] = 16'h9000;
    do_reset();
    run = 1'b1;
    repeat (6) @(negedge clock);
    chk("illegal_fault", {30'd0, fault}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      @(negedge clock);
      if (mem_req || fault != 2'd1 || halted) ok = 1'b0;
    end
    chk("illegal_sticky", {31'd0, ok}, 32'd1);
    do_reset();
    chk("illegal_cleared", {30'd0, fault}, 32'd0);

    // Responder never acks: timeout after 15 waiting cycles.
    clear_mem();
    never_ack = 1'b1;
    do_reset();
    run  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (mem_req) seen = 1'b1;
    end
    chk("to_req_seen", {31'd0, seen}, 32'd1);
    ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k < 15) begin
        if (!mem_req || fault != 2'd0) ok = 1'b0;
      end
    end
    chk("to_wait_window", {31'd0, ok}, 32'd1);
    chk("to_fault", {30'd0, fault},   32'd2);
    chk("to_req",   {31'd0, mem_req}, 32'd0);
    never_ack = 1'b0;
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
